lu_serial_sequencer: RTL and testbench

- Bit-serial initiator for the 1-bit logic unit function set (AND, OR, NOT X, XOR).
- Accepts word-wide operands and a 2-bit op through a valid/ready handshake, then applies the selected function one bit per cycle, LSB first.
- Returns the assembled word through a second valid/ready handshake.
- Sits between the ALU control path and the word-level result bus.

---
 rtl/lu_serial_sequencer.sv | 158 +++++++++++++++
 tb/tb_lu_serial_sequencer.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/lu_serial_sequencer.sv
// Bit-serial AND/OR/NOT/XOR sequencer: word request in, one bit per cycle LSB first, word result out.
// Optional LU_ZERO_FLAG_EN adds a registered result==0 flag on the zero port.
module lu_serial_sequencer #(
   parameter int WIDTH = 8,
   parameter int CNT_W = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start_valid,
   output logic             start_ready,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             res_valid,
   input  logic             res_ready,
   output logic [WIDTH-1:0] result,
   output logic             busy,
   output logic [CNT_W-1:0] bit_idx
`ifdef LU_ZERO_FLAG_EN
   ,
   output logic             zero
`endif
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIDTH - 1);

   state_t             state_r, state_s;
   logic [1:0]         op_r, op_s;
   logic [WIDTH-1:0]   a_r, a_s;
   logic [WIDTH-1:0]   b_r, b_s;
   logic [WIDTH-1:0]   result_r, result_s;
   logic [CNT_W-1:0]   bit_idx_r, bit_idx_s;
   logic               res_valid_r, res_valid_s;
   logic               busy_r, busy_s;
`ifdef LU_ZERO_FLAG_EN
   logic               zero_r, zero_s;
`endif

   // S1 S0 select: 00 AND, 01 OR, 10 NOT X, 11 XOR
   function automatic logic lu_bit(input logic [1:0] sel, input logic x, input logic y);
      logic r;
      case (sel)
         2'b00:   r = x & y;
         2'b01:   r = x | y;
         2'b10:   r = ~x;
         2'b11:   r = x ^ y;
         default: r = 1'b0;
      endcase
      return r;
   endfunction

   // Next-state and datapath decode; res_valid lags DONE entry by one cycle so the final word is registered first
   always_comb begin
      state_s     = state_r;
      op_s        = op_r;
      a_s         = a_r;
      b_s         = b_r;
      result_s    = result_r;
      bit_idx_s   = bit_idx_r;
      res_valid_s = res_valid_r;
      busy_s      = busy_r;
`ifdef LU_ZERO_FLAG_EN
      zero_s      = zero_r;
`endif
      case (state_r)
         IDLE: begin
            if (start_valid) begin
               op_s      = op;
               a_s       = a;
               b_s       = b;
               result_s  = {WIDTH{1'b0}};
               bit_idx_s = {CNT_W{1'b0}};
               busy_s    = 1'b1;
               state_s   = RUN;
            end else begin
               state_s   = IDLE;
            end
         end
         RUN: begin
            result_s[bit_idx_r] = lu_bit(op_r, a_r[bit_idx_r], b_r[bit_idx_r]);
            if (bit_idx_r == LAST_IDX) begin
               bit_idx_s = {CNT_W{1'b0}};
               state_s   = DONE;
`ifdef LU_ZERO_FLAG_EN
               zero_s    = (result_s == {WIDTH{1'b0}});
`endif
            end else begin
               bit_idx_s = bit_idx_r + CNT_W'(1);
            end
         end
         DONE: begin
            if (!res_valid_r) begin
               res_valid_s = 1'b1;
            end else if (res_ready) begin
               res_valid_s = 1'b0;
               busy_s      = 1'b0;
               state_s     = IDLE;
`ifdef LU_ZERO_FLAG_EN
               zero_s      = 1'b0;
`endif
            end else begin
               res_valid_s = 1'b1;
            end
         end
         default: begin
            state_s     = IDLE;
            bit_idx_s   = {CNT_W{1'b0}};
            res_valid_s = 1'b0;
            busy_s      = 1'b0;
         end
      endcase
   end

   // State and datapath registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r     <= IDLE;
         op_r        <= 2'b00;
         a_r         <= {WIDTH{1'b0}};
         b_r         <= {WIDTH{1'b0}};
         result_r    <= {WIDTH{1'b0}};
         bit_idx_r   <= {CNT_W{1'b0}};
         res_valid_r <= 1'b0;
         busy_r      <= 1'b0;
`ifdef LU_ZERO_FLAG_EN
         zero_r      <= 1'b0;
`endif
      end else begin
         state_r     <= state_s;
         op_r        <= op_s;
         a_r         <= a_s;
         b_r         <= b_s;
         result_r    <= result_s;
         bit_idx_r   <= bit_idx_s;
         res_valid_r <= res_valid_s;
         busy_r      <= busy_s;
`ifdef LU_ZERO_FLAG_EN
         zero_r      <= zero_s;
`endif
      end
   end

   assign start_ready = (state_r == IDLE);
   assign res_valid   = res_valid_r;
   assign result      = result_r;
   assign busy        = busy_r;
   assign bit_idx     = bit_idx_r;
`ifdef LU_ZERO_FLAG_EN
   assign zero        = zero_r;
`endif

endmodule

// File: tb/tb_lu_serial_sequencer.sv
// Self-checking bench for lu_serial_sequencer (WIDTH=8): vector table plus handwritten corner sequences,
// results checked through a scoreboard queue filled at request acceptance.
module tb_lu_serial_sequencer;

   logic       clk = 1'b0;
   logic       rst;
   logic       start_valid;
   logic       start_ready;
   logic [1:0] op;
   logic [7:0] a;
   logic [7:0] b;
   logic       res_valid;
   logic       res_ready;
   logic [7:0] result;
   logic       busy;
   logic [2:0] bit_idx;
`ifdef LU_ZERO_FLAG_EN
   logic       zero;
`endif

   lu_serial_sequencer #(.WIDTH(8)) dut (
      .clk(clk), .rst(rst),
      .start_valid(start_valid), .start_ready(start_ready),
      .op(op), .a(a), .b(b),
      .res_valid(res_valid), .res_ready(res_ready),
      .result(result), .busy(busy), .bit_idx(bit_idx)
`ifdef LU_ZERO_FLAG_EN
      , .zero(zero)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [1:0] op;
      logic [7:0] a;
      logic [7:0] b;
      logic [7:0] exp;
      logic       zexp;
   } vec_t;

   typedef struct {
      logic [7:0] res;
      logic       z;
      int         acc;
   } sb_t;

   vec_t tbl [6];
   sb_t  sb [$];
   int   total = 0;
   int   bad = 0;
   int   cyc = 0;
   int   done_cnt = 0;
   int   hs_cyc = 0;
   logic [7:0] last_res = 8'h00;
   logic prev_rv = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic logic [7:0] model(input logic [1:0] o, input logic [7:0] x, input logic [7:0] y);
      case (o)
         2'b00:   return x & y;
         2'b01:   return x | y;
         2'b10:   return ~x;
         default: return x ^ y;
      endcase
   endfunction

   always @(posedge clk) cyc <= cyc + 1;

   // Scoreboard monitor: push on accept, pop on result handshake, flush on reset
   always @(negedge clk) begin
      sb_t e;
      if (rst) begin
         sb.delete();
         prev_rv = 1'b0;
      end else begin
         if (res_valid && !prev_rv) begin
            if (sb.size() == 0) begin
               total++; bad++;
               $display("FAIL unexpected_valid: result=%0h with no pending request", result);
            end else begin
               chk("latency", cyc - sb[0].acc, 9);
            end
         end
         if (res_valid && res_ready) begin
            if (sb.size() == 0) begin
               total++; bad++;
               $display("FAIL unexpected_result: result=%0h with no pending request", result);
            end else begin
               e = sb.pop_front();
               chk("sb_result", result, e.res);
`ifdef LU_ZERO_FLAG_EN
               chk("sb_zero", zero, e.z);
`endif
            end
            last_res = result;
            hs_cyc   = cyc;
            done_cnt++;
         end
         if (start_valid && start_ready) begin
            e.res = model(op, a, b);
            e.z   = (e.res == 8'h00);
            e.acc = cyc + 1;
            sb.push_back(e);
         end
         prev_rv = res_valid;
      end
   end

   task automatic send(input logic [1:0] o, input logic [7:0] x, input logic [7:0] y);
      bit ok = 1'b0;
      @(posedge clk); #1;
      start_valid = 1'b1; op = o; a = x; b = y;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (start_ready) begin ok = 1'b1; break; end
      end
      if (!ok) chk("accept_timeout", 0, 1);
      @(posedge clk); #1;
      start_valid = 1'b0;
   endtask

   task automatic wait_done(input int target);
      bit ok = 1'b0;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (done_cnt >= target) begin ok = 1'b1; break; end
      end
      if (!ok) chk("result_timeout", done_cnt, target);
   endtask

   initial begin
      int exp_done = 0;
      int prev_hs = 0;
      bit seen;

      tbl[0] = '{2'b00, 8'hCA, 8'h0F, 8'h0A, 1'b0};
      tbl[1] = '{2'b01, 8'hCA, 8'h0F, 8'hCF, 1'b0};
      tbl[2] = '{2'b10, 8'hCA, 8'h0F, 8'h35, 1'b0};
      tbl[3] = '{2'b11, 8'hCA, 8'h0F, 8'hC5, 1'b0};
      tbl[4] = '{2'b00, 8'hF0, 8'h0F, 8'h00, 1'b1};
      tbl[5] = '{2'b01, 8'hF0, 8'h0F, 8'hFF, 1'b0};

      rst = 1'b1; start_valid = 1'b0; op = 2'b00; a = 8'h00; b = 8'h00; res_ready = 1'b0;
      @(posedge clk); #1;
      @(negedge clk);
      chk("rst_result", result, 8'h00);
      chk("rst_res_valid", res_valid, 1'b0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_bit_idx", bit_idx, 3'd0);
      chk("rst_start_ready", start_ready, 1'b1);
`ifdef LU_ZERO_FLAG_EN
      chk("rst_zero", zero, 1'b0);
`endif
      @(posedge clk); #1;
      rst = 1'b0;

      // function table, bit_idx sweep during RUN
      res_ready = 1'b1;
      for (int t = 0; t < 6; t++) begin
         send(tbl[t].op, tbl[t].a, tbl[t].b);
         for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("run_bit_idx", bit_idx, i);
            chk("run_busy", busy, 1'b1);
         end
         exp_done++;
         wait_done(exp_done);
         chk("tbl_result", last_res, tbl[t].exp);
      end

      // backpressure: hold result while new requests are offered
      res_ready = 1'b0;
      send(2'b00, 8'hCA, 8'h0F);
      seen = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (res_valid) begin seen = 1'b1; break; end
      end
      chk("bp_valid_seen", seen, 1'b1);
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         start_valid = ~start_valid; op = 2'b01; a = 8'h11; b = 8'h22;
         @(negedge clk);
         chk("bp_res_valid", res_valid, 1'b1);
         chk("bp_result", result, 8'h0A);
         chk("bp_start_ready", start_ready, 1'b0);
      end
      @(posedge clk); #1;
      start_valid = 1'b1; res_ready = 1'b1;
      @(negedge clk);
      chk("bp_still_done", start_ready, 1'b0);
      @(negedge clk);
      chk("bp_idle_ready", start_ready, 1'b1);
      chk("bp_idle_busy", busy, 1'b0);
      chk("bp_idle_valid", res_valid, 1'b0);
      chk("bp_first_res", last_res, 8'h0A);
      @(posedge clk); #1;
      start_valid = 1'b0;
      exp_done += 2;
      wait_done(exp_done);
      chk("bp_next_res", last_res, 8'h33);

      // operands change after capture
      send(2'b11, 8'hFF, 8'h00);
      a = 8'h00; b = 8'hFF;
      exp_done++;
      wait_done(exp_done);
      chk("opchg_result", last_res, 8'hFF);

      // reset after three bits of RUN
      send(2'b01, 8'hF0, 8'h0F);
      repeat (3) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      chk("mrst_result", result, 8'h00);
      chk("mrst_res_valid", res_valid, 1'b0);
      chk("mrst_busy", busy, 1'b0);
      chk("mrst_start_ready", start_ready, 1'b1);
      chk("mrst_bit_idx", bit_idx, 3'd0);
      chk("mrst_no_result", done_cnt, exp_done);
      send(2'b01, 8'hF0, 8'h0F);
      exp_done++;
      wait_done(exp_done);
      chk("mrst_fresh", last_res, 8'hFF);

      // back-to-back with both handshakes tied high
      @(posedge clk); #1;
      res_ready = 1'b1; start_valid = 1'b1; op = 2'b00; a = 8'hFF; b = 8'h3C;
      for (int k = 0; k < 4; k++) begin
         exp_done++;
         wait_done(exp_done);
         chk("b2b_result", last_res, 8'h3C);
         if (k > 0) chk("b2b_spacing", hs_cyc - prev_hs, 11);
         prev_hs = hs_cyc;
      end
      start_valid = 1'b0;
      repeat (15) @(posedge clk);
      @(negedge clk);
      chk("sb_drained", sb.size(), 0);
      chk("final_done_cnt", done_cnt, exp_done);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
